enc16to4_scan_activelow: RTL and testbench
==========================================

Name: enc16to4_scan_activelow

Overview:
- Sequential 16-to-4 encoder with active-low request inputs.
- Performs the reverse of the active-low 4-to-16 decode path.
- Captures a 16-bit active-low request vector on a load strobe, then emits the 4-bit index of every asserted (low) line, one per accepted handshake, in priority order.
- Sits between active-low select/interrupt lines and downstream logic that consumes binary indices.

Parameters:
- LSB_FIRST, 1, scan order: 1 = lowest asserted index first; 0 = highest asserted index first.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- nreq  input  16  request vector; bit i low means line i requested.
- load  input  1  capture strobe; honoured only when busy=0.
- busy  output  1  high while captured requests remain to be emitted.
- code  output  4  binary index of the current request; 0 when valid=0.
- valid  output  1  code is meaningful.
- ready  input  1  consumer accepts code when valid&&ready.
- done  output  1  one-cycle pulse after the last pending index is accepted.
- none  output  1  one-cycle pulse when a load captured no asserted lines (nreq=16'hFFFF).

Behaviour:
- Internal state: pend[15:0] (active-high pending mask, pend = ~nreq at capture) and FSM {IDLE, EMIT}.
- Reset (rstn=0 at clk edge):
  - pend=0, state=IDLE.
  - busy=0, valid=0, code=0, done=0, none=0.
  - Reset mid-EMIT discards all pending indices; no done pulse is generated.
- IDLE, load=1:
  - Capture pend <= ~nreq.
  - If ~nreq != 0: go to EMIT; valid and busy rise the next cycle (1-cycle latency).
  - If ~nreq == 0: stay in IDLE; none=1 for exactly the next cycle.
- IDLE, load=0: hold; all outputs low.
- EMIT:
  - valid=1, busy=1.
  - code = priority encode of pend (lowest set bit if LSB_FIRST=1, else highest set bit). Code is combinational from registered pend.
  - valid&&ready: clear pend[code].
    - If the cleared bit was the last one: next cycle state=IDLE, valid=0, busy=0, done=1 for one cycle.
    - Otherwise: next code is presented the following cycle.
  - valid && !ready: code and pend hold stable, with no limit on the number of stall cycles.
- load while busy=1 is ignored, including the cycle of the final handshake. A new load is accepted from the cycle in which busy=0, which may coincide with the done pulse.
- done and none are never both high.
- nreq is sampled only at capture; changes during EMIT have no effect.
- Throughput: one index per cycle with ready held high. N asserted lines are emitted in N consecutive cycles starting 1 cycle after load.

Optional Feature:
- Macro: ENC_COUNT_EN.
- Defined:
  - Adds output port cnt[4:0] = popcount(pend), i.e. the number of indices still pending including the current one.
  - cnt is 0 in IDLE and after reset.
  - cnt decrements by 1 on each accepted handshake.
- Undefined: port cnt and its logic are absent; all other behaviour is identical.

Decomposition:
- Package enc_scan_pkg:
  - State typedef {IDLE, EMIT}.
  - Constants REQ_W=16, CODE_W=4, GRP_W=4.
- Sub-module enc4to2_activelow: combinational 4-to-2 priority encoder with active-low inputs, a direction select, and an active-low "none" output.
  - Instantiated four times on the nibbles of ~pend (one per nibble).
  - Instantiated once on the four group-none signals.
  - code[3:2] comes from the group-level encoder; code[1:0] is muxed from the selected nibble encoder.

Test Plan:
- Reset then load with nreq=16'hFFFE, ready=1: valid=1, code=0 one cycle after load; done=1 the following cycle; busy returns to 0.
- LSB_FIRST=1, nreq=16'h7FF6 (lines 0,3,15 low), ready=1: code sequence 0,3,15 on consecutive cycles; done one cycle after code=15 is accepted. With LSB_FIRST=0, the sequence is 15,3,0.
- nreq=16'hFFFF with load: none pulses one cycle; valid, busy and done stay 0.
- nreq=16'h0FFF (lines 12–15), ready low for 3 cycles after valid rises: code=12 held stable for 3 cycles, then 12,13,14,15 once ready=1. A load issued mid-stream with a different nreq is ignored.
- rstn=0 after the second of four indices is accepted: the next cycle shows valid=0, busy=0, code=0, and no done pulse. A subsequent load behaves normally.
- ENC_COUNT_EN defined, nreq=16'h0000: cnt=16 at the first valid and decrements to 1 at the last index; done fires after exactly 16 handshakes.

Source files
------------

// File: rtl/enc_scan_pkg.sv
// rtl/enc_scan_pkg.sv - shared widths, FSM state type and popcount helper for the 16-to-4 scan encoder
package enc_scan_pkg;

    localparam int REQ_W  = 16;
    localparam int CODE_W = 4;
    localparam int GRP_W  = 4;
    localparam int CNT_W  = CODE_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] popcount(input logic [REQ_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < REQ_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/enc16to4_scan_activelow_if.sv
// rtl/enc16to4_scan_activelow_if.sv - request capture / index handshake bundle; cnt present only with ENC_COUNT_EN
interface enc16to4_scan_activelow_if;
    import enc_scan_pkg::*;

    logic [REQ_W-1:0]  nreq;
    logic              load;
    logic              busy;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              ready;
    logic              done;
    logic              none;
`ifdef ENC_COUNT_EN
    logic [CNT_W-1:0]  cnt;

    modport master (
        output nreq, load, ready,
        input  busy, code, valid, done, none, cnt
    );

    modport slave (
        input  nreq, load, ready,
        output busy, code, valid, done, none, cnt
    );
`else
    modport master (
        output nreq, load, ready,
        input  busy, code, valid, done, none
    );

    modport slave (
        input  nreq, load, ready,
        output busy, code, valid, done, none
    );
`endif

endinterface

// File: rtl/enc4to2_activelow.sv
// rtl/enc4to2_activelow.sv - combinational 4-to-2 priority encoder, active-low inputs and active-low none
module enc4to2_activelow (
    input  logic [3:0] nreq_i,
    input  logic       lsb_first_i,
    output logic [1:0] code_o,
    output logic       none_n_o
);

    logic [3:0] req;

    assign req      = ~nreq_i;
    assign none_n_o = |req;

    // Later loop iterations overwrite earlier ones, so the last hit wins.
    always_comb begin
        code_o = 2'd0;
        if (lsb_first_i) begin
            for (int i = 3; i >= 0; i--) begin
                if (req[i]) code_o = 2'(i);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) code_o = 2'(i);
            end
        end
    end

endmodule

// File: rtl/enc16to4_scan_activelow.sv
// rtl/enc16to4_scan_activelow.sv - captures active-low requests and emits one index per handshake; ENC_COUNT_EN adds cnt
module enc16to4_scan_activelow #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rstn,
    enc16to4_scan_activelow_if.slave    bus
);
    import enc_scan_pkg::*;

    localparam int NGRP = REQ_W / GRP_W;

    state_e            state_q, state_d;
    logic [REQ_W-1:0]  pend_q, pend_d;
    logic              done_q, done_d;
    logic              none_q, none_d;

    logic [NGRP-1:0]   grp_none_n;
    logic [1:0]        nib_code [NGRP];
    logic [1:0]        grp_code;
    logic              grp_any;
    logic [CODE_W-1:0] cur_code;
    logic              valid;

    for (genvar g = 0; g < NGRP; g++) begin : g_nib
        enc4to2_activelow u_nib (
            .nreq_i      (~pend_q[g*GRP_W +: GRP_W]),
            .lsb_first_i (LSB_FIRST),
            .code_o      (nib_code[g]),
            .none_n_o    (grp_none_n[g])
        );
    end

    // A group counts as a request at this level when its nibble is non-empty.
    enc4to2_activelow u_grp (
        .nreq_i      (~grp_none_n),
        .lsb_first_i (LSB_FIRST),
        .code_o      (grp_code),
        .none_n_o    (grp_any)
    );

    assign cur_code = {grp_code, nib_code[grp_code]};
    assign valid    = (state_q == EMIT) && grp_any;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        none_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    pend_d = ~bus.nreq;
                    if (bus.nreq == '1) begin
                        none_d = 1'b1;
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (valid && bus.ready) begin
                    pend_d = pend_q & ~(REQ_W'(1) << cur_code);
                    if (pend_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            pend_q  <= '0;
            done_q  <= 1'b0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            none_q  <= none_d;
        end
    end

    assign bus.busy  = (state_q == EMIT);
    assign bus.valid = valid;
    assign bus.code  = valid ? cur_code : '0;
    assign bus.done  = done_q;
    assign bus.none  = none_q;
`ifdef ENC_COUNT_EN
    assign bus.cnt   = popcount(pend_q);
`endif

endmodule

// File: tb/tb_enc16to4_scan_activelow.sv
// tb/tb_enc16to4_scan_activelow.sv - both scan orders against a queue-based index model, directed then random
module tb_enc16to4_scan_activelow;

    logic        clk = 1'b0;
    logic        rstn_r;
    logic        load_r;
    logic        ready_r;
    logic [15:0] nreq_r;

    int n_tests = 0;
    int n_fail  = 0;

    int q_l[$];
    int q_m[$];
    bit e_done;
    bit e_none;

    always #5 clk = ~clk;

    enc16to4_scan_activelow_if bus_l ();
    enc16to4_scan_activelow_if bus_m ();

    assign bus_l.nreq  = nreq_r;
    assign bus_l.load  = load_r;
    assign bus_l.ready = ready_r;
    assign bus_m.nreq  = nreq_r;
    assign bus_m.load  = load_r;
    assign bus_m.ready = ready_r;

    enc16to4_scan_activelow #(.LSB_FIRST(1'b1)) u_dut_lsb (
        .clk  (clk),
        .rstn (rstn_r),
        .bus  (bus_l)
    );

    enc16to4_scan_activelow #(.LSB_FIRST(1'b0)) u_dut_msb (
        .clk  (clk),
        .rstn (rstn_r),
        .bus  (bus_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void build(input logic [15:0] n);
        q_l.delete();
        q_m.delete();
        for (int i = 0; i < 16; i++) if (!n[i]) q_l.push_back(i);
        for (int i = 15; i >= 0; i--) if (!n[i]) q_m.push_back(i);
    endfunction

    // Compare the current outputs with the model, then apply the next inputs
    // and advance the model by one clock.
    task automatic step(input logic r, input logic l, input logic rd, input logic [15:0] n);
        bit busy_m;
        chk("valid_lsb", bus_l.valid, q_l.size() != 0);
        chk("busy_lsb",  bus_l.busy,  q_l.size() != 0);
        chk("code_lsb",  bus_l.code,  (q_l.size() != 0) ? q_l[0] : 0);
        chk("done_lsb",  bus_l.done,  e_done);
        chk("none_lsb",  bus_l.none,  e_none);
        chk("valid_msb", bus_m.valid, q_m.size() != 0);
        chk("busy_msb",  bus_m.busy,  q_m.size() != 0);
        chk("code_msb",  bus_m.code,  (q_m.size() != 0) ? q_m[0] : 0);
        chk("done_msb",  bus_m.done,  e_done);
        chk("none_msb",  bus_m.none,  e_none);
`ifdef ENC_COUNT_EN
        chk("cnt_lsb",   bus_l.cnt,   q_l.size());
        chk("cnt_msb",   bus_m.cnt,   q_m.size());
`endif
        rstn_r  = r;
        load_r  = l;
        ready_r = rd;
        nreq_r  = n;
        busy_m  = (q_l.size() != 0);
        e_done  = 1'b0;
        e_none  = 1'b0;
        if (!r) begin
            q_l.delete();
            q_m.delete();
        end else if (busy_m) begin
            if (rd) begin
                void'(q_l.pop_front());
                void'(q_m.pop_front());
                if (q_l.size() == 0) e_done = 1'b1;
            end
        end else if (l) begin
            build(n);
            if (q_l.size() == 0) e_none = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_nreq();
        logic [15:0] v;
        case ($urandom_range(0, 3))
            0:       v = 16'hFFFF;
            1:       v = ~(16'h0001 << $urandom_range(0, 15));
            2:       v = 16'($urandom);
            default: v = 16'($urandom) | 16'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        rstn_r  = 1'b0;
        load_r  = 1'b0;
        ready_r = 1'b0;
        nreq_r  = 16'hFFFF;
        e_done  = 1'b0;
        e_none  = 1'b0;
        repeat (2) @(negedge clk);

        // single line 0
        step(1'b1, 1'b1, 1'b1, 16'hFFFE);
        repeat (3) step(1'b1, 1'b0, 1'b1, 16'hFFFF);

        // lines 0, 3, 15
        step(1'b1, 1'b1, 1'b1, 16'h7FF6);
        repeat (5) step(1'b1, 1'b0, 1'b1, 16'hFFFF);

        // empty capture
        step(1'b1, 1'b1, 1'b1, 16'hFFFF);
        repeat (2) step(1'b1, 1'b0, 1'b1, 16'hFFFF);

        // lines 12..15 with stall, mid-stream load must be ignored
        step(1'b1, 1'b1, 1'b0, 16'h0FFF);
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 1'b1, 16'hFFFE);
        repeat (5) step(1'b1, 1'b0, 1'b1, 16'hFFFF);

        // reset after two of four accepted, then a normal load
        step(1'b1, 1'b1, 1'b0, 16'hEEEE);
        repeat (2) step(1'b1, 1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b0, 1'b1, 16'hFFFF);
        repeat (2) step(1'b1, 1'b0, 1'b1, 16'hFFFF);
        step(1'b1, 1'b1, 1'b1, 16'hFF5F);
        repeat (4) step(1'b1, 1'b0, 1'b1, 16'hFFFF);

        // all sixteen lines, then a load coinciding with done
        step(1'b1, 1'b1, 1'b1, 16'h0000);
        repeat (16) step(1'b1, 1'b0, 1'b1, 16'hFFFF);
        step(1'b1, 1'b1, 1'b1, 16'hBFFF);
        repeat (3) step(1'b1, 1'b0, 1'b1, 16'hFFFF);

        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0,
                 rand_nreq());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
